// File: rtl/ibex_fp_rf_write_ctrl.sv
// FP register-file write controller: merges FPU and load results into a small FIFO
// drained one write per cycle, with a per-register pending-write scoreboard.
// Define IBEX_FP_RF_WB_ASSERT_EN to compile in the SVA checks.
module ibex_fp_rf_write_ctrl #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 fpu_valid_i,
  output logic                 fpu_ready_o,
  input  logic [4:0]           fpu_waddr_i,
  input  logic [DataWidth-1:0] fpu_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic                 rsv_i,
  input  logic [4:0]           rsv_addr_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           raddr_c_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o,
  output logic                 busy_c_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [4:0]           addr_mem [Depth];
  logic [DataWidth-1:0] data_mem [Depth];
  logic [31:1]          sb_q, sb_d;
  logic [31:0]          sb_vec, sb_n;

  logic       full, pop, push, lsu_acc, fpu_acc;
  logic [4:0] push_addr;
  logic [DataWidth-1:0] push_data;

  // Handshake: a result transfers on a cycle where valid && ready; ready depends
  // only on the registered occupancy and (for the FPU) the load's priority claim.
  assign full        = (count_q == CW'(Depth));
  assign lsu_ready_o = !full;
  assign fpu_ready_o = !full && !lsu_valid_i;
  assign lsu_acc     = lsu_valid_i && lsu_ready_o;
  assign fpu_acc     = fpu_valid_i && fpu_ready_o;
  assign push_addr   = lsu_acc ? lsu_waddr_i : fpu_waddr_i;
  assign push_data   = lsu_acc ? lsu_wdata_i : fpu_wdata_i;
  // Results for x0 complete the handshake but never reach the FIFO.
  assign push        = (lsu_acc || fpu_acc) && (push_addr != 5'd0);

  // The register file never back-pressures, so the head pops whenever present.
  assign empty_o    = (count_q == '0);
  assign pop        = !empty_o;
  assign rf_we_o    = pop;
  assign rf_waddr_o = addr_mem[rptr_q];
  assign rf_wdata_o = data_mem[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign sb_vec = {sb_q, 1'b0};

  // Clear first, then set, so a same-cycle reservation wins over the write.
  always_comb begin
    sb_n = sb_vec;
    if (rf_we_o) sb_n[rf_waddr_o] = 1'b0;
    if (rsv_i)   sb_n[rsv_addr_i] = 1'b1;
    sb_n[0] = 1'b0;
    sb_d    = sb_n[31:1];
  end

  assign busy_a_o = sb_vec[raddr_a_i];
  assign busy_b_o = sb_vec[raddr_b_i];
  assign busy_c_o = sb_vec[raddr_c_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      sb_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      sb_q    <= sb_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wptr_q] <= push_addr;
      data_mem[wptr_q] <= push_data;
    end
  end

`ifdef IBEX_FP_RF_WB_ASSERT_EN
  a_depth_pow2: assert property (@(posedge clk_i)
    (Depth >= 2) && ((Depth & (Depth - 1)) == 0));
  a_rsv_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    rsv_i |-> (!sb_vec[rsv_addr_i] || (rf_we_o && rf_waddr_o == rsv_addr_i)));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    full |-> !push);
  a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= CW'(Depth));
  a_no_x0_write: assert property (@(posedge clk_i) disable iff (rst_i)
    rf_we_o |-> (rf_waddr_o != 5'd0));
`endif

endmodule

// File: tb/tb_ibex_fp_rf_write_ctrl.sv
// Self-checking bench for ibex_fp_rf_write_ctrl: directed steps then random traffic,
// every cycle compared against a queue-and-array reference model.
module tb_ibex_fp_rf_write_ctrl;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          fpu_valid_i, lsu_valid_i, rsv_i;
  logic          fpu_ready_o, lsu_ready_o;
  logic [4:0]    fpu_waddr_i, lsu_waddr_i, rsv_addr_i;
  logic [DW-1:0] fpu_wdata_i, lsu_wdata_i;
  logic [4:0]    raddr_a_i, raddr_b_i, raddr_c_i;
  logic          busy_a_o, busy_b_o, busy_c_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          rf_we_o, empty_o;

  ibex_fp_rf_write_ctrl #(.DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
    .fpu_waddr_i(fpu_waddr_i), .fpu_wdata_i(fpu_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .busy_a_o(busy_a_o), .busy_b_o(busy_b_o), .busy_c_o(busy_c_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
    .empty_o(empty_o)
  );

  // clock/reset block
  always #5 clk_i = ~clk_i;

  // reference model: pending results in arrival order, and one busy flag per register
  logic [DW+4:0] exp_q[$];
  bit            busy_m[32];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int r = 0; r < 32; r++) busy_m[r] = 1'b0;
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic cycle(input logic lv, input logic [4:0] la, input logic [DW-1:0] ld,
                       input logic fv, input logic [4:0] fa, input logic [DW-1:0] fd,
                       input logic rv, input logic [4:0] rva,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    logic [DW+4:0] head;
    bit full, we_exp;
    lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
    fpu_valid_i = fv; fpu_waddr_i = fa; fpu_wdata_i = fd;
    rsv_i = rv; rsv_addr_i = rva;
    raddr_a_i = a; raddr_b_i = b; raddr_c_i = c;
    #2;
    full   = (exp_q.size() == DEPTH);
    we_exp = (exp_q.size() != 0);
    chk("rf_we", DW'(rf_we_o), DW'(we_exp));
    chk("empty", DW'(empty_o), DW'(exp_q.size() == 0));
    chk("lsu_ready", DW'(lsu_ready_o), DW'(!full));
    chk("fpu_ready", DW'(fpu_ready_o), DW'(!full && !lv));
    chk("busy_a", DW'(busy_a_o), DW'(a != 0 && busy_m[a]));
    chk("busy_b", DW'(busy_b_o), DW'(b != 0 && busy_m[b]));
    chk("busy_c", DW'(busy_c_o), DW'(c != 0 && busy_m[c]));
    if (we_exp) begin
      head = exp_q.pop_front();
      chk("rf_waddr", DW'(rf_waddr_o), DW'(head[DW+4:DW]));
      chk("rf_wdata", rf_wdata_o, head[DW-1:0]);
      busy_m[head[DW+4:DW]] = 1'b0;
    end
    if (lv && !full) begin
      if (la != 0) exp_q.push_back({la, ld});
    end else if (fv && !full) begin
      if (fa != 0) exp_q.push_back({fa, fd});
    end
    if (rv && rva != 0) busy_m[rva] = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic [4:0] a);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, a, 0, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    fpu_valid_i = 0; lsu_valid_i = 0; rsv_i = 0;
    fpu_waddr_i = 0; lsu_waddr_i = 0; rsv_addr_i = 0;
    fpu_wdata_i = 0; lsu_wdata_i = 0;
    raddr_a_i = 0; raddr_b_i = 0; raddr_c_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_we", DW'(rf_we_o), 0);
    chk("reset_empty", DW'(empty_o), 1);
    chk("reset_fpu_ready", DW'(fpu_ready_o), 1);
    rst_i = 1'b0;
    idle(0);

    // single FPU write, latency one cycle
    cycle(0, 0, 0, 1, 5'd5, 32'h3F800000, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);

    // LSU priority: load first, FPU held off one cycle
    cycle(1, 5'd3, 32'hAAAA0000, 1, 5'd4, 32'h55550000, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 5'd4, 32'h55550000, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);

    // five back-to-back loads, then both producers valid together
    for (int i = 0; i < 5; i++)
      cycle(1, 5'(10 + i), 32'hC0DE0000 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5'd20, 32'h12345678, 1, 5'd21, 32'h87654321, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);

    // reservation and release of x7
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 0);
    idle(5'd7);
    cycle(0, 0, 0, 1, 5'd7, 32'hDEADBEEF, 0, 0, 5'd7, 0, 0);
    idle(5'd7);
    idle(5'd7);

    // set and clear of x9 in the same cycle
    cycle(0, 0, 0, 1, 5'd9, 32'h00000909, 0, 0, 0, 5'd9, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9, 0);
    idle(0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);

    // x0 results: accepted, never written
    cycle(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    cycle(1, 5'd0, 32'hEEEEEEEE, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);

    // reset with a queued write and reservations outstanding
    cycle(1, 5'd12, 32'h0000ABCD, 0, 0, 0, 1, 5'd12, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd13, 5'd12, 5'd13, 0);
    lsu_valid_i = 1; lsu_waddr_i = 5'd14; lsu_wdata_i = 32'h1;
    raddr_a_i = 5'd12; raddr_b_i = 5'd13; raddr_c_i = 5'd14;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_we", DW'(rf_we_o), 0);
    chk("rst_mid_empty", DW'(empty_o), 1);
    chk("rst_mid_busy", DW'({busy_a_o, busy_b_o, busy_c_o}), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    idle(5'd12);
    idle(5'd13);

    // random traffic; reservations only target registers the model shows idle
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ra;
      logic rv;
      ra = 5'($urandom_range(0, 31));
      rv = ($urandom_range(0, 2) == 0) && !busy_m[ra];
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            rv, ra,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end
    repeat (3) idle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
